// File: rtl/hr_xfer_fifo.sv
// Per-port transfer buffer between a hierarchical-ring bridge and its ring: circular FIFO
// with occupancy, sticky error flags and optional stats (enable with HR_XFER_FIFO_STATS_EN).
module hr_xfer_fifo #(
   parameter int DATA_W       = 144,
   parameter int DEPTH        = 4,
   parameter int AW           = 2,
   parameter int BFULL_MARGIN = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enQ_i,
   input  logic [DATA_W-1:0] FIFO_i,
   input  logic              deQ_i,
   output logic [DATA_W-1:0] FIFO_o,
   output logic              bfull_o,
   output logic [AW:0]       count_o,
   output logic              ovf_o,
   output logic              udf_o,
   output logic [AW:0]       peak_o,
   output logic [31:0]       flits_o
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam int          THRESH  = DEPTH - BFULL_MARGIN;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [AW:0]       count, count_nxt;
   logic              pop_eff, push_acc;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
   assign pop_eff  = deQ_i && (count != '0);
   assign push_acc = enQ_i && ((count < DEPTH_C) || pop_eff);

   always_comb begin
      count_nxt = count;
      if (push_acc && !pop_eff)
         count_nxt = count + (AW+1)'(1);
      else if (!push_acc && pop_eff)
         count_nxt = count - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf_o  <= 1'b0;
         udf_o  <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + AW'(1);
         if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         if (enQ_i && !push_acc)       ovf_o <= 1'b1;
         if (deQ_i && (count == '0))   udf_o <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_ptr] <= FIFO_i;
   end

   // Zero head means idle to the bridge; no bypass, so a push shows up one cycle later.
   assign FIFO_o  = (count == '0) ? '0 : mem[rd_ptr];
   assign bfull_o = (int'(count) >= THRESH);
   assign count_o = count;

`ifdef HR_XFER_FIFO_STATS_EN
   logic [AW:0] peak;
   logic [31:0] flits;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         peak  <= '0;
         flits <= '0;
      end else begin
         if (count_nxt > peak) peak <= count_nxt;
         if (push_acc && (flits != 32'hFFFF_FFFF)) flits <= flits + 32'd1;
      end
   end

   assign peak_o  = peak;
   assign flits_o = flits;
`else
   assign peak_o  = '0;
   assign flits_o = '0;
`endif

endmodule
